sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param_if.sv | 29 ++
 rtl/sync_fifo_param.sv | 99 +++++++++
 tb/tb_sync_fifo_param.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle for sync_fifo_param.
// The master drives the write/read requests; the slave (the FIFO) returns data and status.
interface sync_fifo_param_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  logic                       flush;
  logic                       wrt_en;
  logic [WIDTH-1:0]           wrt;
  logic                       rd_en;
  logic [WIDTH-1:0]           rd;
  logic                       full;
  logic                       empty;
  logic                       almost_full;
  logic                       almost_empty;
  logic [$clog2(DEPTH):0]     count;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output flush, wrt_en, wrt, rd_en,
    input  rd, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wrt_en, wrt, rd_en,
    output rd, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with wrap-bit pointers, registered read data,
// threshold flags and sticky overflow/underflow error flags.
module sync_fifo_param #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  sync_fifo_param_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrt_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] rd_q;
  logic             overflow_q;
  logic             underflow_q;

  logic             lo_eq;
  logic             full_c;
  logic             empty_c;
  logic [PW-1:0]    count_c;
  logic             rd_acc;
  logic             wr_acc;

  // Status is derived straight from the registered pointers: equal low bits
  // mean full when the wrap bits differ and empty when they match.
  assign lo_eq   = (wrt_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign full_c  = lo_eq && (wrt_ptr[AW] != rd_ptr[AW]);
  assign empty_c = lo_eq && (wrt_ptr[AW] == rd_ptr[AW]);
  assign count_c = wrt_ptr - rd_ptr;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write
  // alongside a read. An empty FIFO never bypasses write data to the reader.
  // Flush blocks both sides.
  assign rd_acc = bus.rd_en && !empty_c && !bus.flush;
  assign wr_acc = bus.wrt_en && (!full_c || rd_acc) && !bus.flush;

  assign bus.rd           = rd_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.count        = count_c;
  assign bus.almost_full  = (count_c >= AF_L);
  assign bus.almost_empty = (count_c <= AE_L);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  // Storage array: written on accepted writes only, never reset or flushed.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wrt_ptr[AW-1:0]] <= bus.wrt;
    end
  end

  // Pointers advance modulo 2*DEPTH; flush rewinds both without touching memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrt_ptr <= '0;
      rd_ptr  <= '0;
    end else if (bus.flush) begin
      wrt_ptr <= '0;
      rd_ptr  <= '0;
    end else begin
      if (wr_acc) wrt_ptr <= wrt_ptr + 1'b1;
      if (rd_acc) rd_ptr  <= rd_ptr + 1'b1;
    end
  end

  // Read data register: loads on an accepted read, otherwise holds (including on flush).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else if (rd_acc) begin
      rd_q <= mem[rd_ptr[AW-1:0]];
    end
  end

  // Sticky error flags: set on any rejected request, cleared only by flush or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wrt_en && !wr_acc) overflow_q  <= 1'b1;
      if (bus.rd_en && !rd_acc)  underflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a queue-based reference model predicts status and
// read data; a separate monitor pops expected read data whenever the FIFO
// accepts a read.
module tb_sync_fifo_param;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_rd  = '0;
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_status(input string tag);
    int c;
    c = mq.size();
    check({tag, ".count"},        int'(bus.count),        c);
    check({tag, ".full"},         int'(bus.full),         int'(c == DEPTH));
    check({tag, ".empty"},        int'(bus.empty),        int'(c == 0));
    check({tag, ".almost_full"},  int'(bus.almost_full),  int'(c >= AF));
    check({tag, ".almost_empty"}, int'(bus.almost_empty), int'(c <= AE));
    check({tag, ".overflow"},     int'(bus.overflow),     int'(m_ovf));
    check({tag, ".underflow"},    int'(bus.underflow),    int'(m_unf));
    check({tag, ".rd"},           int'(bus.rd),           int'(m_rd));
  endtask

  // One clock of stimulus plus the model's view of what that clock does.
  task automatic cycle(input bit we, input logic [WIDTH-1:0] wd,
                       input bit re, input bit fl, input string tag);
    bit racc;
    bit wacc;
    @(negedge clk);
    bus.wrt_en = we;
    bus.wrt    = wd;
    bus.rd_en  = re;
    bus.flush  = fl;
    if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      racc = re && (mq.size() > 0);
      wacc = we && ((mq.size() < DEPTH) || racc);
      if (racc) begin
        m_rd = mq.pop_front();
        exp_q.push_back(m_rd);
      end else if (re) begin
        m_unf = 1'b1;
      end
      if (wacc) mq.push_back(wd);
      else if (we) m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_status(tag);
  endtask

  // Monitor: a read is presented when the FIFO accepted one on this edge.
  always @(posedge clk) begin
    bit fire;
    logic [WIDTH-1:0] e;
    fire = bus.rd_en && !bus.empty && !bus.flush && !rst;
    #1;
    if (fire) begin
      if (exp_q.size() == 0) begin
        check("scoreboard.unexpected_read", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("scoreboard.rd", int'(bus.rd), int'(e));
      end
    end
  end

  initial begin
    bus.flush  = 1'b0;
    bus.wrt_en = 1'b0;
    bus.wrt    = '0;
    bus.rd_en  = 1'b0;

    // Reset state
    #2;
    check_status("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Fill 1..8: thresholds cross at the expected counts
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0, "fill");
    check("fill.full_const", int'(bus.full), 1);
    check("fill.count_const", int'(bus.count), 8);

    // Write while full is dropped
    cycle(1'b1, 4'h9, 1'b0, 1'b0, "ovf");
    check("ovf.sticky_const", int'(bus.overflow), 1);

    // Full with simultaneous read/write: both accepted, 0xA goes last
    cycle(1'b1, 4'hA, 1'b1, 1'b0, "full_rw");
    check("full_rw.rd_const", int'(bus.rd), 1);
    check("full_rw.full_const", int'(bus.full), 1);

    // Drain everything, then one read too many
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, "drain");
    check("drain.last_const", int'(bus.rd), 10);
    cycle(1'b0, '0, 1'b1, 1'b0, "unf");

    // Empty with simultaneous read/write: no bypass
    cycle(1'b1, 4'h5, 1'b1, 1'b0, "empty_rw");
    cycle(1'b0, '0, 1'b1, 1'b0, "empty_rw_next");
    check("empty_rw.rd_const", int'(bus.rd), 5);

    // Continuous streaming across two pointer wraps
    cycle(1'b1, 4'h0, 1'b0, 1'b0, "stream_prime");
    for (int i = 1; i < 20; i++) cycle(1'b1, WIDTH'(i), 1'b1, 1'b0, "stream");
    cycle(1'b0, '0, 1'b1, 1'b0, "stream_tail");

    // Count 4 with overflow set, then flush
    for (int i = 0; i < 4; i++) cycle(1'b1, WIDTH'(i + 3), 1'b0, 1'b0, "pre_flush");
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'hC, 1'b0, 1'b0, "fill_ovf");
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, "to_four");
    cycle(1'b1, 4'hF, 1'b1, 1'b1, "flush");
    check("flush.count_const", int'(bus.count), 0);

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), WIDTH'($urandom),
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 3), "rand");
    end

    // Asynchronous reset mid-burst, observed before any further clock edge
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(i + 7), 1'b1, 1'b0, "burst");
    cycle(1'b1, 4'h2, 1'b0, 1'b0, "burst_w");
    #1;
    rst = 1'b1;
    mq.delete();
    m_rd  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    check_status("async_rst");
    bus.wrt_en = 1'b0;
    bus.rd_en  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 4'h6, 1'b0, 1'b0, "post_rst");
    cycle(1'b0, '0, 1'b1, 1'b0, "post_rst_rd");

    #2;
    check("scoreboard.drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
